// File: rtl/vector_pkg.sv
// ============================================================================
// vector_pkg
//   Shared SEW encodings, mask-packer state type and lane-count helper.
//   Rev 1.0
// ============================================================================
`default_nettype none

package vector_pkg;

  localparam int MASK_W = 64;

  localparam logic [1:0] SEW_8  = 2'b00;
  localparam logic [1:0] SEW_16 = 2'b01;
  localparam logic [1:0] SEW_32 = 2'b10;
  localparam logic [1:0] SEW_64 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_OUTPUT  = 2'd2
  } mask_packer_state_t;

  // Mask bits carried per adder fragment: one per element in a 64-bit chunk.
  function automatic logic [3:0] sew_lanes(input logic [1:0] vsew);
    return 4'd8 >> vsew;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mask_fragment_placer.sv
// ============================================================================
// mask_fragment_placer
//   Scatters one adder carry fragment to mask positions ptr..ptr+n-1 (< vl).
//   Rev 1.0
// ============================================================================
`default_nettype none

module mask_fragment_placer #(
  parameter int MASK_W = 64,
  parameter int VL_W   = 7
) (
  input  logic [7:0]        frag_i,
  input  logic [6:0]        ptr,
  input  logic [VL_W-1:0]   vl,
  input  logic [1:0]        vsew,
  output logic [MASK_W-1:0] wr_en_o,
  output logic [MASK_W-1:0] wr_data_o
);
  import vector_pkg::*;

  logic [3:0] w_lanes;

  assign w_lanes = sew_lanes(vsew);

  // Each mask bit picks the fragment lane at its offset from ptr, if that
  // lane exists for this SEW and the bit lies below vl.
  for (genvar i = 0; i < MASK_W; i++) begin : g_bit
    localparam logic [7:0] c_IDX = 8'(i);
    logic [7:0] w_off;

    assign w_off        = c_IDX - 8'(ptr);
    assign wr_en_o[i]   = (c_IDX >= 8'(ptr)) && (w_off < 8'(w_lanes)) && (c_IDX < 8'(vl));
    assign wr_data_o[i] = wr_en_o[i] & frag_i[w_off[2:0]];
  end

endmodule

`default_nettype wire

// File: rtl/vector_carry_mask_packer.sv
// ============================================================================
// vector_carry_mask_packer
//   Collects per-chunk vmadc/vmsbc carry fragments into one mask word.
//   Rev 1.0
// ============================================================================
`default_nettype none

module vector_carry_mask_packer #(
  parameter int MASK_W = 64,
  parameter int VL_W   = 7
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              flush_i,
  input  logic              start_i,
  input  logic [VL_W-1:0]   vl_i,
  input  logic [1:0]        vsew_i,
  input  logic              frag_valid_i,
  output logic              frag_ready_o,
  input  logic [7:0]        frag_i,
  output logic              mask_valid_o,
  input  logic              mask_ready_i,
  output logic [MASK_W-1:0] mask_o,
  output logic              busy_o
);
  import vector_pkg::*;

  localparam int              c_PTR_W  = 7;
  localparam logic [VL_W-1:0] c_VL_MAX = VL_W'(MASK_W);

  mask_packer_state_t r_state;
  logic [c_PTR_W-1:0] r_ptr;
  logic [VL_W-1:0]    r_vl;
  logic [1:0]         r_vsew;
  logic [MASK_W-1:0]  r_acc;

  logic [VL_W-1:0]    w_vl_clamp;
  logic [3:0]         w_lanes;
  logic               w_last;
  logic [MASK_W-1:0]  w_wr_en;
  logic [MASK_W-1:0]  w_wr_data;

  assign w_vl_clamp = (vl_i > c_VL_MAX) ? c_VL_MAX : vl_i;
  assign w_lanes    = sew_lanes(r_vsew);
  assign w_last     = (8'(r_ptr) + 8'(w_lanes)) >= 8'(r_vl);

  mask_fragment_placer #(
    .MASK_W (MASK_W),
    .VL_W   (VL_W)
  ) u_placer (
    .frag_i    (frag_i),
    .ptr       (r_ptr),
    .vl        (r_vl),
    .vsew      (r_vsew),
    .wr_en_o   (w_wr_en),
    .wr_data_o (w_wr_data)
  );

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_vl    <= '0;
      r_vsew  <= '0;
      r_acc   <= '0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_vl    <= w_vl_clamp;
            r_vsew  <= vsew_i;
            r_ptr   <= '0;
            r_acc   <= '0;
            r_state <= (w_vl_clamp == '0) ? ST_OUTPUT : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (frag_valid_i) begin
            r_acc <= (r_acc & ~w_wr_en) | w_wr_data;
            r_ptr <= r_ptr + c_PTR_W'(w_lanes);
            if (w_last) begin
              r_state <= ST_OUTPUT;
            end
          end
        end
        ST_OUTPUT: begin
          // The word leaves with the handshake; the cleared acc keeps mask_o
          // at zero while idle.
          if (mask_ready_i) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign frag_ready_o = (r_state == ST_COLLECT);
  assign mask_valid_o = (r_state == ST_OUTPUT);
  assign busy_o       = (r_state != ST_IDLE);
  assign mask_o       = r_acc;

endmodule

`default_nettype wire

// File: tb/tb_vector_carry_mask_packer.sv
// ============================================================================
// tb_vector_carry_mask_packer
//   Randomized and directed checks against an element-level mask model.
//   Rev 1.0
// ============================================================================
`default_nettype none

module tb_vector_carry_mask_packer;

  logic        clk = 1'b0;
  logic        rsn_i;
  logic        flush_i;
  logic        start_i;
  logic [6:0]  vl_i;
  logic [1:0]  vsew_i;
  logic        frag_valid_i;
  logic        frag_ready_o;
  logic [7:0]  frag_i;
  logic        mask_valid_o;
  logic        mask_ready_i;
  logic [63:0] mask_o;
  logic        busy_o;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0] fr [64];

  vector_carry_mask_packer #(
    .MASK_W (64),
    .VL_W   (7)
  ) dut (
    .clk_i        (clk),
    .rsn_i        (rsn_i),
    .flush_i      (flush_i),
    .start_i      (start_i),
    .vl_i         (vl_i),
    .vsew_i       (vsew_i),
    .frag_valid_i (frag_valid_i),
    .frag_ready_o (frag_ready_o),
    .frag_i       (frag_i),
    .mask_valid_o (mask_valid_o),
    .mask_ready_i (mask_ready_i),
    .mask_o       (mask_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Element e of the mask comes from fragment e/n, lane e%n.
  function automatic logic [63:0] model_mask(input int vl, input int sew);
    logic [63:0] m;
    int n, vlc;
    m   = '0;
    n   = 8 >> sew;
    vlc = (vl > 64) ? 64 : vl;
    for (int e = 0; e < vlc; e++) begin
      m[e] = fr[e / n][e % n];
    end
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation with optional source gaps and sink stalls.
  task automatic run_op(input int vl, input int sew, input int max_gap, input int stall,
                        input string name, output logic [63:0] got);
    int n, vlc, cnt, gap;
    logic [63:0] exp_mask;
    n        = 8 >> sew;
    vlc      = (vl > 64) ? 64 : vl;
    cnt      = (vlc + n - 1) / n;
    exp_mask = model_mask(vl, sew);

    start_i = 1'b1;
    vl_i    = 7'(vl);
    vsew_i  = 2'(sew);
    tick();
    start_i = 1'b0;
    tests_run++;
    if ((vlc == 0 && mask_valid_o !== 1'b1) || (vlc != 0 && frag_ready_o !== 1'b1)) begin
      tests_failed++;
      $display("FAIL %s start: frag_ready=%b mask_valid=%b vl=%0d", name, frag_ready_o, mask_valid_o, vlc);
    end

    for (int i = 0; i < cnt; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      frag_valid_i = 1'b0;
      repeat (gap) tick();
      frag_valid_i = 1'b1;
      frag_i       = fr[i];
      tests_run++;
      if (frag_ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL %s handshake %0d of %0d: frag_ready=%b, need 1", name, i + 1, cnt, frag_ready_o);
      end
      tick();
    end
    frag_valid_i = 1'b0;

    tests_run++;
    if (mask_valid_o !== 1'b1 || frag_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s output latency: mask_valid=%b frag_ready=%b, need 1/0", name, mask_valid_o, frag_ready_o);
    end
    tests_run++;
    if (mask_o !== exp_mask) begin
      tests_failed++;
      $display("FAIL %s mask: got %h need %h", name, mask_o, exp_mask);
    end
    got = mask_o;

    frag_valid_i = (stall > 0);
    frag_i       = 8'hFF;
    for (int s = 0; s < stall; s++) begin
      tick();
      tests_run++;
      if (mask_valid_o !== 1'b1 || frag_ready_o !== 1'b0 || mask_o !== exp_mask) begin
        tests_failed++;
        $display("FAIL %s stall %0d: valid=%b ready=%b mask %h need %h", name, s, mask_valid_o, frag_ready_o, mask_o, exp_mask);
      end
    end
    frag_valid_i = 1'b0;

    mask_ready_i = 1'b1;
    tick();
    mask_ready_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0 || mask_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s return to idle: busy=%b mask_valid=%b, need 0/0", name, busy_o, mask_valid_o);
    end
  endtask

  task automatic test_reset();
    rsn_i = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({frag_ready_o, mask_valid_o, busy_o} !== 3'b000 || mask_o !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset values: ready=%b valid=%b busy=%b mask=%h, need all 0", frag_ready_o, mask_valid_o, busy_o, mask_o);
    end
    rsn_i = 1'b1;
    tick();
    tests_run++;
    if (busy_o !== 1'b0 || mask_o !== 64'h0) begin
      tests_failed++;
      $display("FAIL idle after reset: busy=%b mask=%h, need 0/0", busy_o, mask_o);
    end
  endtask

  task automatic test_sew8();
    logic [63:0] got;
    fr[0] = 8'hA5;
    fr[1] = 8'h3C;
    run_op(16, 0, 0, 0, "sew8", got);
    tests_run++;
    if (got !== 64'h3CA5) begin
      tests_failed++;
      $display("FAIL sew8 constant: got %h need 3ca5", got);
    end
  endtask

  task automatic test_sew32_partial();
    logic [63:0] got;
    fr[0] = 8'h03;
    fr[1] = 8'h03;
    fr[2] = 8'hFF;
    run_op(5, 2, 0, 0, "sew32_partial", got);
    tests_run++;
    if (got !== 64'h1F) begin
      tests_failed++;
      $display("FAIL sew32_partial constant: got %h need 1f", got);
    end
  endtask

  task automatic test_sew64_and_vl_zero();
    logic [63:0] got;
    fr[0] = 8'h01;
    fr[1] = 8'h00;
    fr[2] = 8'hFF;
    run_op(3, 3, 0, 0, "sew64", got);
    tests_run++;
    if (got !== 64'h5) begin
      tests_failed++;
      $display("FAIL sew64 constant: got %h need 5", got);
    end
    run_op(0, 0, 0, 2, "vl_zero", got);
    tests_run++;
    if (got !== 64'h0) begin
      tests_failed++;
      $display("FAIL vl_zero constant: got %h need 0", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got;
    fr[0] = 8'h0A;
    run_op(4, 1, 0, 5, "backpressure", got);
    tests_run++;
    if (got !== 64'hA) begin
      tests_failed++;
      $display("FAIL backpressure constant: got %h need a", got);
    end
    fr[0] = 8'h5A;
    run_op(8, 0, 0, 0, "back_to_back", got);
    tests_run++;
    if (got !== 64'h5A) begin
      tests_failed++;
      $display("FAIL back_to_back constant: got %h need 5a", got);
    end
  endtask

  task automatic test_flush();
    logic [63:0] got;
    start_i = 1'b1;
    vl_i    = 7'd64;
    vsew_i  = 2'd0;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      frag_valid_i = 1'b1;
      frag_i       = 8'(32'($urandom) | 32'h1);
      tick();
    end
    frag_i  = 8'hFF;
    flush_i = 1'b1;
    tick();
    flush_i      = 1'b0;
    frag_valid_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0 || frag_ready_o !== 1'b0 || mask_o !== 64'h0) begin
      tests_failed++;
      $display("FAIL flush: busy=%b ready=%b mask=%h, need 0/0/0", busy_o, frag_ready_o, mask_o);
    end
    fr[0] = 8'h81;
    run_op(8, 0, 0, 0, "after_flush", got);
    tests_run++;
    if (got !== 64'h81) begin
      tests_failed++;
      $display("FAIL after_flush constant: got %h need 81", got);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] got;
    start_i = 1'b1;
    vl_i    = 7'd8;
    vsew_i  = 2'd0;
    tick();
    start_i      = 1'b0;
    frag_valid_i = 1'b1;
    frag_i       = 8'hFF;
    tick();
    frag_valid_i = 1'b0;
    tests_run++;
    if (mask_valid_o !== 1'b1 || mask_o !== 64'hFF) begin
      tests_failed++;
      $display("FAIL pre-reset output: valid=%b mask=%h need 1/ff", mask_valid_o, mask_o);
    end
    #2;
    rsn_i = 1'b0;
    #1;
    tests_run++;
    if ({frag_ready_o, mask_valid_o, busy_o} !== 3'b000 || mask_o !== 64'h0) begin
      tests_failed++;
      $display("FAIL async reset: ready=%b valid=%b busy=%b mask=%h, need all 0", frag_ready_o, mask_valid_o, busy_o, mask_o);
    end
    tick();
    rsn_i = 1'b1;
    tick();
    fr[0] = 8'h81;
    run_op(8, 0, 0, 0, "after_reset", got);
    tests_run++;
    if (got !== 64'h81) begin
      tests_failed++;
      $display("FAIL after_reset constant: got %h need 81", got);
    end
  endtask

  task automatic test_ignored_start_and_clamp();
    start_i = 1'b1;
    vl_i    = 7'd100;
    vsew_i  = 2'd0;
    tick();
    vl_i   = 7'd8;
    vsew_i = 2'd3;
    for (int i = 0; i < 8; i++) begin
      frag_valid_i = 1'b1;
      frag_i       = 8'hFF;
      tests_run++;
      if (frag_ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL clamp handshake %0d: frag_ready=%b, need 1", i, frag_ready_o);
      end
      tick();
    end
    frag_valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    tests_run++;
    if (mask_valid_o !== 1'b1 || mask_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      tests_failed++;
      $display("FAIL clamp mask: valid=%b mask=%h need 1/ffffffffffffffff", mask_valid_o, mask_o);
    end
    mask_ready_i = 1'b1;
    tick();
    mask_ready_i = 1'b0;
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL clamp idle: busy=%b need 0", busy_o);
    end
  endtask

  task automatic test_random();
    logic [63:0] got;
    int vl, sew;
    for (int op = 0; op < 30; op++) begin
      for (int i = 0; i < 64; i++) fr[i] = 8'($urandom);
      sew = int'($urandom_range(0, 3));
      vl  = (op % 7 == 6) ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 64));
      run_op(vl, sew, 2, int'($urandom_range(0, 3)), "random", got);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rsn_i        = 1'b0;
    flush_i      = 1'b0;
    start_i      = 1'b0;
    vl_i         = '0;
    vsew_i       = '0;
    frag_valid_i = 1'b0;
    frag_i       = '0;
    mask_ready_i = 1'b0;
    for (int i = 0; i < 64; i++) fr[i] = '0;

    test_reset();
    test_sew8();
    test_sew32_partial();
    test_sew64_and_vl_zero();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_ignored_start_and_clamp();
    test_random();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
